// File: rtl/pu_riscv_ex_result_reg_if.sv
// pu_riscv_ex_result_reg_if: EX-stage result/handshake bundle between the EX/MEM register and its neighbours
interface pu_riscv_ex_result_reg_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            ex_flush;
    logic            mem_stall;
    logic            id_bubble;
    logic [ILEN-1:0] id_instr;
    logic [1:0]      id_unit;
    logic            id_word;
    logic [XLEN-1:0] alu_r;
    logic            mul_bubble;
    logic            mul_stall;
    logic [XLEN-1:0] mul_r;
    logic            div_bubble;
    logic            div_stall;
    logic [XLEN-1:0] div_r;
    logic            ex_stall;
    logic            ex_bubble;
    logic [ILEN-1:0] ex_instr;
    logic [XLEN-1:0] ex_r;

    modport master (
        input  ex_flush, mem_stall, id_bubble, id_instr, id_unit, id_word, alu_r,
        input  mul_bubble, mul_stall, mul_r, div_bubble, div_stall, div_r,
        output ex_stall, ex_bubble, ex_instr, ex_r
    );

    modport slave (
        output ex_flush, mem_stall, id_bubble, id_instr, id_unit, id_word, alu_r,
        output mul_bubble, mul_stall, mul_r, div_bubble, div_stall, div_r,
        input  ex_stall, ex_bubble, ex_instr, ex_r
    );
endinterface

// File: rtl/pu_riscv_ex_result_reg.sv
// pu_riscv_ex_result_reg: EX result select (ALU/MUL/DIV), multi-cycle wait sequencing and EX/MEM register
module pu_riscv_ex_result_reg #(
    parameter int              XLEN      = 64,
    parameter int              ILEN      = 32,
    parameter logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013
) (
    input logic                    clk,
    input logic                    rstn,
    pu_riscv_ex_result_reg_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT_MUL, WAIT_DIV, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] r_q, r_nxt;
    logic [ILEN-1:0] instr_q, instr_nxt, pend_q, pend_nxt;
    logic            bubble_q, bubble_nxt, word_q, word_nxt;
    logic            mul_done, div_done, flush_drain;

    function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] r, input logic w);
        return (XLEN == 64 && w) ? XLEN'($signed(r[31:0])) : r;
    endfunction

    assign mul_done    = !bus.mul_bubble && !bus.mul_stall && !bus.mem_stall;
    assign div_done    = !bus.div_bubble && !bus.div_stall && !bus.mem_stall;
    assign flush_drain = state == WAIT_MUL ? bus.mul_stall :
                         state == WAIT_DIV ? bus.div_stall : bus.mul_stall || bus.div_stall;

    assign bus.ex_stall  = bus.mem_stall || state != IDLE;
    assign bus.ex_bubble = bubble_q;
    assign bus.ex_instr  = instr_q;
    assign bus.ex_r      = r_q;

    // Next state and next register contents; flush overrides everything but reset
    always_comb begin
        state_nxt  = state;
        r_nxt      = r_q;
        instr_nxt  = instr_q;
        bubble_nxt = bubble_q;
        pend_nxt   = pend_q;
        word_nxt   = word_q;
        if (bus.ex_flush) begin
            bubble_nxt = 1'b1;
            instr_nxt  = INSTR_NOP;
            pend_nxt   = INSTR_NOP;
            word_nxt   = 1'b0;
            state_nxt  = flush_drain ? DRAIN : IDLE;
        end else begin
            case (state)
                IDLE: if (!bus.mem_stall) begin
                    if (bus.id_bubble) begin
                        bubble_nxt = 1'b1;
                        instr_nxt  = INSTR_NOP;
                    end else if (bus.id_unit == 2'b01 || bus.id_unit == 2'b10) begin
                        pend_nxt   = bus.id_instr;
                        word_nxt   = bus.id_word;
                        bubble_nxt = 1'b1;
                        state_nxt  = bus.id_unit == 2'b01 ? WAIT_MUL : WAIT_DIV;
                    end else begin
                        r_nxt      = bus.id_unit == 2'b00 ? ext(bus.alu_r, bus.id_word) : '0;
                        instr_nxt  = bus.id_instr;
                        bubble_nxt = 1'b0;
                    end
                end
                WAIT_MUL: if (mul_done) begin
                    r_nxt      = ext(bus.mul_r, word_q);
                    instr_nxt  = pend_q;
                    bubble_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
                WAIT_DIV: if (div_done) begin
                    r_nxt      = ext(bus.div_r, word_q);
                    instr_nxt  = pend_q;
                    bubble_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
                DRAIN: if (!bus.mul_stall && !bus.div_stall) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and EX/MEM register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            r_q      <= '0;
            instr_q  <= INSTR_NOP;
            bubble_q <= 1'b1;
            pend_q   <= '0;
            word_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            r_q      <= r_nxt;
            instr_q  <= instr_nxt;
            bubble_q <= bubble_nxt;
            pend_q   <= pend_nxt;
            word_q   <= word_nxt;
        end
    end
endmodule

// File: tb/tb_pu_riscv_ex_result_reg.sv
// tb_pu_riscv_ex_result_reg: directed and random checks of the EX result register against a behavioural model
module tb_pu_riscv_ex_result_reg;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pu_riscv_ex_result_reg_if #(.XLEN(64), .ILEN(32)) bus ();

    pu_riscv_ex_result_reg #(.XLEN(64), .ILEN(32), .INSTR_NOP(NOP)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.master)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    logic        m_bub   = 1'b1;
    logic [63:0] m_r     = '0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pi    = '0;
    logic        m_pw    = 1'b0;
    int          m_wait  = 0;
    bit          m_drain = 1'b0;

    function automatic logic [63:0] mext(input logic [63:0] r, input logic w);
        return w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pipeline outcome per edge from the documented rules
    initial forever begin
        @(posedge clk);
        if (!rstn) begin
            m_bub = 1; m_r = 0; m_instr = NOP; m_wait = 0; m_drain = 0;
        end else if (bus.ex_flush) begin
            m_drain = m_wait == 1 ? bus.mul_stall : m_wait == 2 ? bus.div_stall : (bus.mul_stall | bus.div_stall);
            m_bub = 1; m_instr = NOP; m_wait = 0;
        end else if (m_drain) begin
            if (!bus.mul_stall && !bus.div_stall) m_drain = 0;
        end else if (m_wait == 1) begin
            if (!bus.mul_bubble && !bus.mul_stall && !bus.mem_stall) begin
                m_r = mext(bus.mul_r, m_pw); m_instr = m_pi; m_bub = 0; m_wait = 0;
            end
        end else if (m_wait == 2) begin
            if (!bus.div_bubble && !bus.div_stall && !bus.mem_stall) begin
                m_r = mext(bus.div_r, m_pw); m_instr = m_pi; m_bub = 0; m_wait = 0;
            end
        end else if (!bus.mem_stall) begin
            if (bus.id_bubble) begin
                m_bub = 1; m_instr = NOP;
            end else if (bus.id_unit == 1 || bus.id_unit == 2) begin
                m_pi = bus.id_instr; m_pw = bus.id_word; m_bub = 1; m_wait = int'(bus.id_unit);
            end else begin
                m_r = bus.id_unit == 0 ? mext(bus.alu_r, bus.id_word) : 64'd0;
                m_instr = bus.id_instr; m_bub = 0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            logic exp_stall;
            exp_stall = bus.mem_stall | (m_wait != 0) | m_drain;
            checks++;
            if (bus.ex_bubble !== m_bub || bus.ex_r !== m_r || bus.ex_instr !== m_instr || bus.ex_stall !== exp_stall) begin
                failures++;
                $display("FAIL model t=%0t got bub=%b r=%h instr=%h stall=%b exp bub=%b r=%h instr=%h stall=%b",
                         $time, bus.ex_bubble, bus.ex_r, bus.ex_instr, bus.ex_stall, m_bub, m_r, m_instr, exp_stall);
            end
        end
    end

    initial begin
        bus.ex_flush = 0; bus.mem_stall = 0; bus.id_bubble = 1; bus.id_instr = '0; bus.id_unit = 0;
        bus.id_word = 0; bus.alu_r = '0; bus.mul_bubble = 1; bus.mul_stall = 0; bus.mul_r = '0;
        bus.div_bubble = 1; bus.div_stall = 0; bus.div_r = '0;
        tick(); tick();
        cmp_en = 1;
        chk("rst_bubble", 64'(bus.ex_bubble), 64'd1);
        chk("rst_r", bus.ex_r, 64'd0);
        chk("rst_instr", 64'(bus.ex_instr), 64'(NOP));
        rstn = 1;
        // ALU stream
        bus.id_bubble = 0; bus.id_unit = 0; bus.id_instr = 32'h0000_1001; bus.alu_r = 64'd5;
        #1 chk("alu_stall", 64'(bus.ex_stall), 64'd0);
        tick(); chk("alu_r5", bus.ex_r, 64'd5); chk("alu_bub", 64'(bus.ex_bubble), 64'd0);
        bus.alu_r = 64'd6; tick(); chk("alu_r6", bus.ex_r, 64'd6);
        bus.alu_r = 64'd7; tick(); chk("alu_r7", bus.ex_r, 64'd7);
        chk("alu_instr", 64'(bus.ex_instr), 64'h1001);
        // MUL word op with sign extension
        bus.id_unit = 1; bus.id_word = 1; bus.id_instr = 32'h0000_A00B; bus.mul_stall = 1;
        tick(); chk("mul_issue_bub", 64'(bus.ex_bubble), 64'd1);
        bus.id_bubble = 1; #1 chk("mul_wait_stall", 64'(bus.ex_stall), 64'd1);
        tick(); tick();
        bus.mul_stall = 0; bus.mul_bubble = 0; bus.mul_r = 64'h0000_0000_8000_0000;
        #1 chk("mul_cap_stall", 64'(bus.ex_stall), 64'd1);
        tick(); chk("mul_r", bus.ex_r, 64'hFFFF_FFFF_8000_0000);
        chk("mul_instr", 64'(bus.ex_instr), 64'hA00B); chk("mul_bub", 64'(bus.ex_bubble), 64'd0);
        bus.mul_bubble = 1;
        // DIV blocked by mem_stall
        bus.id_bubble = 0; bus.id_unit = 2; bus.id_word = 0; bus.id_instr = 32'h0000_B00B;
        tick();
        bus.id_bubble = 1; bus.div_bubble = 0; bus.div_r = 64'd42; bus.mem_stall = 1;
        tick(); chk("div_hold1", 64'(bus.ex_bubble), 64'd1);
        tick(); chk("div_hold2", 64'(bus.ex_bubble), 64'd1);
        bus.mem_stall = 0; tick();
        chk("div_r", bus.ex_r, 64'd42); chk("div_instr", 64'(bus.ex_instr), 64'hB00B);
        bus.div_bubble = 1;
        // Flush while MUL busy, then drain
        bus.id_bubble = 0; bus.id_unit = 1; bus.id_instr = 32'h0000_C00B; bus.mul_stall = 1;
        tick();
        bus.id_bubble = 1; bus.ex_flush = 1; tick(); bus.ex_flush = 0;
        chk("flush_bub", 64'(bus.ex_bubble), 64'd1); chk("flush_instr", 64'(bus.ex_instr), 64'(NOP));
        tick(); #1 chk("drain_stall", 64'(bus.ex_stall), 64'd1);
        bus.mul_stall = 0; bus.mul_bubble = 0; bus.mul_r = 64'd99;
        tick(); chk("drain_exit_bub", 64'(bus.ex_bubble), 64'd1);
        tick(); chk("drain_ignored", 64'(bus.ex_bubble), 64'd1);
        bus.mul_bubble = 1; bus.id_bubble = 0; bus.id_unit = 0; bus.alu_r = 64'd11; bus.id_instr = 32'h0000_D013;
        tick(); chk("post_drain_alu", bus.ex_r, 64'd11);
        // Reset during WAIT_MUL
        bus.id_unit = 1; bus.id_instr = 32'h0000_E00B; bus.mul_stall = 1;
        tick();
        bus.id_bubble = 1; rstn = 0; tick(); rstn = 1;
        chk("rst_wait_bub", 64'(bus.ex_bubble), 64'd1); chk("rst_wait_r", bus.ex_r, 64'd0);
        chk("rst_wait_instr", 64'(bus.ex_instr), 64'(NOP));
        bus.mul_stall = 0; bus.mul_bubble = 0; bus.mul_r = 64'd77;
        #1 chk("rst_wait_stall", 64'(bus.ex_stall), 64'd0);
        tick(); chk("rst_wait_ignore", 64'(bus.ex_bubble), 64'd1);
        bus.mul_bubble = 1;
        // mem_stall hold, then flush beats mem_stall
        bus.id_bubble = 0; bus.id_unit = 0; bus.alu_r = 64'd3; bus.id_instr = 32'h0000_F013;
        tick(); chk("ms_alu3", bus.ex_r, 64'd3);
        bus.mem_stall = 1; bus.alu_r = 64'd4; #1 chk("ms_stall", 64'(bus.ex_stall), 64'd1);
        tick(); chk("ms_hold", bus.ex_r, 64'd3); chk("ms_hold_bub", 64'(bus.ex_bubble), 64'd0);
        bus.ex_flush = 1; tick(); chk("ms_flush_bub", 64'(bus.ex_bubble), 64'd1);
        bus.ex_flush = 0; bus.mem_stall = 0;
        // Unit none and ALU word ops
        bus.id_unit = 3; bus.alu_r = 64'd5; tick(); chk("none_r", bus.ex_r, 64'd0);
        bus.id_unit = 0; bus.id_word = 1; bus.alu_r = 64'h1234_5678_9ABC_DEF0;
        tick(); chk("alu_word", bus.ex_r, 64'hFFFF_FFFF_9ABC_DEF0);
        bus.id_word = 0; tick(); chk("alu_noword", bus.ex_r, 64'h1234_5678_9ABC_DEF0);
        // Random phase
        repeat (3000) begin
            rstn           = $urandom_range(0, 79) != 0;
            bus.ex_flush   = $urandom_range(0, 19) == 0;
            bus.mem_stall  = $urandom_range(0, 4) == 0;
            bus.id_bubble  = $urandom_range(0, 4) == 0;
            bus.id_instr   = $urandom;
            bus.id_unit    = 2'($urandom_range(0, 3));
            bus.id_word    = 1'($urandom_range(0, 1));
            bus.alu_r      = {$urandom, $urandom};
            bus.mul_stall  = $urandom_range(0, 2) == 0;
            bus.mul_bubble = $urandom_range(0, 1) == 0;
            bus.mul_r      = {$urandom, $urandom};
            bus.div_stall  = $urandom_range(0, 2) == 0;
            bus.div_bubble = $urandom_range(0, 1) == 0;
            bus.div_r      = {$urandom, $urandom};
            tick();
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pu_riscv_ex_result_reg.md
Name: pu_riscv_ex_result_reg

Overview:
EX-stage result collector and EX/MEM pipeline register, directly downstream of the multiplier (mul_r/mul_bubble) and divider.
- Selects per instruction among ALU (single-cycle), MUL and DIV (multi-cycle) results.
- Sequences waits on the multi-cycle units, generates ex_stall back to ID/EX, and holds the registered result under mem_stall.
- Applies RV64 word-op sign extension before the result reaches MEM.

Parameters:
XLEN, 64, datapath width (32 or 64)
ILEN, 32, instruction width
INSTR_NOP, 32'h0000_0013, instruction driven on ex_instr when bubbled/reset

Ports:
clk  in  1  clock; all state on rising edge
rstn  in  1  reset, synchronous, active-low
ex_flush  in  1  kill in-flight EX instruction (branch/exception)
mem_stall  in  1  MEM cannot accept; hold outputs
id_bubble  in  1  ID presents no valid instruction
id_instr  in  ILEN  instruction issued to EX
id_unit  in  2  00=ALU, 01=MUL, 10=DIV, 11=none (result 0)
id_word  in  1  RV64 *W op; sign-extend result[31:0]
alu_r  in  XLEN  ALU result, valid in issue cycle
mul_bubble  in  1  low = mul_r valid
mul_stall  in  1  multiplier busy
mul_r  in  XLEN  multiplier result
div_bubble  in  1  low = div_r valid
div_stall  in  1  divider busy
div_r  in  XLEN  divider result
ex_stall  out  1  stall ID/EX and multi-cycle units
ex_bubble  out  1  ex_r/ex_instr invalid
ex_instr  out  ILEN  registered instruction
ex_r  out  XLEN  registered result

Behaviour:
- Reset (rstn=0 at edge):
  - ex_bubble=1, ex_r=0, ex_instr=INSTR_NOP.
  - state=IDLE; pending instruction and word flag cleared.
  - Applies mid-wait too: any later unit result is ignored.
- ex_stall (combinational) = mem_stall | (state != IDLE).
- MUL/DIV hold their result valid while ex_stall=1; this block relies on that.
- ext(r): XLEN=64 & word → {{32{r[31]}}, r[31:0]}; otherwise r unchanged. Word flag is the issued or pending id_word.
- Priority each edge: rstn > ex_flush > mem_stall > normal.
- IDLE:
  - ex_flush: ex_bubble<=1, ex_instr<=INSTR_NOP. Go DRAIN if mul_stall|div_stall, else stay IDLE.
  - mem_stall: hold all outputs.
  - id_bubble: ex_bubble<=1, ex_instr<=INSTR_NOP.
  - unit ALU: ex_r<=ext(alu_r), ex_instr<=id_instr, ex_bubble<=0. Latency 1.
  - unit none: same as ALU but ex_r<=0.
  - unit MUL/DIV: latch id_instr and id_word into pending; ex_bubble<=1; go WAIT_MUL / WAIT_DIV.
- WAIT_MUL:
  - Capture condition: !mul_bubble & !mul_stall & !mem_stall.
  - On capture: ex_r<=ext(mul_r), ex_instr<=pending, ex_bubble<=0, go IDLE.
  - Otherwise hold. If mem_stall blocks capture, stay in WAIT_MUL; the result stays held because ex_stall=1.
- WAIT_DIV: identical, using div_bubble/div_stall/div_r.
- Flush while waiting: ex_bubble<=1, pending discarded. Go DRAIN if the awaited unit's stall=1, else IDLE.
- DRAIN: outputs stay bubbled; go IDLE when mul_stall=0 & div_stall=0. Unit results are never captured in DRAIN.
- Throughput:
  - ex_stall=1 in the capture cycle, so the next ID instruction is accepted one cycle after returning to IDLE.
  - Back-to-back ALU ops: one per cycle.
- id_unit, id_word and alu_r are sampled only in IDLE with ex_stall=0.

Test Plan:
1. Reset, then ALU stream: alu_r=5,6,7, id_unit=00, id_bubble=0 → ex_r=5,6,7 on consecutive cycles, ex_bubble=0, ex_stall=0 throughout.
2. MUL issue, XLEN=64, id_word=1; mul_stall high 3 cycles, then mul_bubble=0, mul_r=64'h0000_0000_8000_0000 → ex_stall=1 from the cycle after issue through capture; ex_r=64'hFFFF_FFFF_8000_0000; ex_instr=issued instr.
3. DIV completes while mem_stall=1 for 2 cycles → state stays WAIT_DIV, outputs unchanged; capture on the first cycle mem_stall=0; div_r=42 appears at ex_r.
4. MUL in flight with mul_stall=1, ex_flush pulses → ex_bubble=1 next cycle; DRAIN until mul_stall=0; later mul_bubble=0 result never appears; next ALU op issues normally.
5. rstn=0 for one cycle during WAIT_MUL → ex_bubble=1, ex_r=0, ex_instr=32'h13, ex_stall=mem_stall; a subsequent mul result is ignored.
6. mem_stall=1 in IDLE with a valid ALU instr → ex_stall=1, outputs held; flush asserted together with mem_stall → ex_bubble=1 (flush wins).
